adcmux_scan_ctrl: RTL and testbench

//   Scan sequencer for the 4:1 analog input mux in front of the housekeeping ADC.

---
 rtl/adcmux_scan_ctrl_if.sv | 26 ++
 rtl/adcmux_scan_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_adcmux_scan_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/adcmux_scan_ctrl_if.sv
// Analog mux select and ADC conversion handshake between the scan sequencer and the ADC macro.
interface adcmux_scan_ctrl_if #(
  parameter int RES_W = 10
);
  logic             mux_msb;
  logic             mux_lsb;
  logic             adc_start;
  logic             adc_done;
  logic [RES_W-1:0] adc_data;

  modport master (
    output mux_msb,
    output mux_lsb,
    output adc_start,
    input  adc_done,
    input  adc_data
  );

  modport slave (
    input  mux_msb,
    input  mux_lsb,
    input  adc_start,
    output adc_done,
    output adc_data
  );
endinterface

// File: rtl/adcmux_scan_ctrl.sv
// Scan sequencer for the 4:1 housekeeping ADC input mux: select, settle, convert, store per channel.
// Optional build macro ADCMUX_SCAN_AVG_EN: average four back-to-back conversions per channel.
module adcmux_scan_ctrl #(
  parameter int RES_W       = 10,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_en,
  input  logic [3:0]           cfg_chmask,
  input  logic                 cfg_cont,
  input  logic                 start,
  adcmux_scan_ctrl_if.master   adc,
  output logic                 busy,
  output logic                 res_valid,
  output logic [1:0]           res_ch,
  output logic [4*RES_W-1:0]   res_all,
  output logic                 round_done,
  output logic                 err_timeout
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, CONVERT, STORE} state_t;

  state_t           state;
  state_t           next_state;
  logic [3:0]       mask_q;
  logic [1:0]       ch;
  logic [1:0]       mux_sel;
  logic [SW-1:0]    settle_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic             issue;
  logic             tmo_flag;
  logic [RES_W-1:0] acc;
  logic             adc_start_c;
  logic             conv_hit;
  logic             conv_tmo;
  logic [2:0]       start_pick;
  logic [2:0]       adv_pick;
`ifdef ADCMUX_SCAN_AVG_EN
  logic [RES_W+1:0] sum;
  logic [RES_W+1:0] sum_next;
  logic [1:0]       smp;
`endif

  // Lowest set mask bit at or above lo; bit 2 of the result flags that one was found.
  function automatic logic [2:0] pick_from(input logic [3:0] m, input logic [2:0] lo);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i >= int'(lo))) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  assign busy          = (state != IDLE);
  assign adc.adc_start = adc_start_c;
  assign adc.mux_msb   = mux_sel[1];
  assign adc.mux_lsb   = mux_sel[0];
`ifdef ADCMUX_SCAN_AVG_EN
  assign sum_next = sum + {2'b00, adc.adc_data};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Dropping cfg_en forces IDLE and suppresses every strobe in the same cycle.
  always_comb begin
    next_state  = state;
    adc_start_c = 1'b0;
    res_valid   = 1'b0;
    round_done  = 1'b0;
    conv_hit    = 1'b0;
    conv_tmo    = 1'b0;
    start_pick  = pick_from(cfg_chmask, 3'd0);
    adv_pick    = pick_from(mask_q, {1'b0, ch} + 3'd1);
    if (!cfg_en) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && start_pick[2]) next_state = SELECT;
        SELECT:  next_state = SETTLE;
        SETTLE:  if (settle_cnt == SETTLE_LAST) next_state = CONVERT;
        CONVERT: begin
          adc_start_c = issue;
          if (adc.adc_done) begin
            conv_hit = 1'b1;
`ifdef ADCMUX_SCAN_AVG_EN
            if (smp == 2'd3) next_state = STORE;
`else
            next_state = STORE;
`endif
          end else if (tmo_cnt == TIMEOUT_LAST) begin
            conv_tmo   = 1'b1;
            next_state = STORE;
          end
        end
        STORE: begin
          res_valid = !tmo_flag;
          if (adv_pick[2]) begin
            next_state = SELECT;
          end else begin
            round_done = 1'b1;
            next_state = (cfg_cont && start_pick[2]) ? SELECT : IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Datapath follows the current state; nothing moves while the block is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q      <= '0;
      ch          <= '0;
      mux_sel     <= '0;
      res_ch      <= '0;
      res_all     <= '0;
      err_timeout <= 1'b0;
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
      issue       <= 1'b0;
      tmo_flag    <= 1'b0;
      acc         <= '0;
`ifdef ADCMUX_SCAN_AVG_EN
      sum         <= '0;
      smp         <= '0;
`endif
    end else if (cfg_en) begin
      case (state)
        IDLE: begin
          if (start && start_pick[2]) begin
            mask_q      <= cfg_chmask;
            ch          <= start_pick[1:0];
            err_timeout <= 1'b0;
          end
        end
        SELECT: begin
          mux_sel    <= ch;
          res_ch     <= ch;
          settle_cnt <= '0;
          tmo_cnt    <= '0;
          issue      <= 1'b1;
          tmo_flag   <= 1'b0;
`ifdef ADCMUX_SCAN_AVG_EN
          sum        <= '0;
          smp        <= '0;
`endif
        end
        SETTLE: settle_cnt <= settle_cnt + SW'(1);
        CONVERT: begin
          issue   <= 1'b0;
          tmo_cnt <= tmo_cnt + TW'(1);
          if (conv_hit) begin
            tmo_cnt <= '0;
`ifdef ADCMUX_SCAN_AVG_EN
            sum <= sum_next;
            smp <= smp + 2'd1;
            if (smp == 2'd3) acc <= sum_next[RES_W+1:2];
            else             issue <= 1'b1;
`else
            acc <= adc.adc_data;
`endif
          end
          if (conv_tmo) begin
            err_timeout <= 1'b1;
            tmo_flag    <= 1'b1;
          end
        end
        STORE: begin
          if (!tmo_flag) res_all[ch*RES_W +: RES_W] <= acc;
          // The mask is only re-read when a new round begins.
          if (adv_pick[2]) begin
            ch <= adv_pick[1:0];
          end else begin
            ch     <= start_pick[1:0];
            mask_q <= cfg_chmask;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adcmux_scan_ctrl.sv
// Directed bench for adcmux_scan_ctrl with a delayed-done ADC model; honours ADCMUX_SCAN_AVG_EN.
module tb_adcmux_scan_ctrl;
  localparam int RES_W = 10;
`ifdef ADCMUX_SCAN_AVG_EN
  localparam int NS      = 4;
  localparam int SEQ_EXP = 11;
`else
  localparam int NS      = 1;
  localparam int SEQ_EXP = 10;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_en;
  logic [3:0]       cfg_chmask;
  logic             cfg_cont;
  logic             start;
  logic             busy;
  logic             res_valid;
  logic [1:0]       res_ch;
  logic [4*RES_W-1:0] res_all;
  logic             round_done;
  logic             err_timeout;

  adcmux_scan_ctrl_if #(.RES_W(RES_W)) adc ();

  adcmux_scan_ctrl #(.RES_W(RES_W), .SETTLE_CYC(16), .TIMEOUT_CYC(1024)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_chmask(cfg_chmask), .cfg_cont(cfg_cont),
    .start(start), .adc(adc), .busy(busy), .res_valid(res_valid), .res_ch(res_ch),
    .res_all(res_all), .round_done(round_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic hang_ch1 = 1'b0;
  logic seq_mode = 1'b0;
  int   offset = 0;

  // ADC model: done strobe five cycles after adc_start, data = ch*100+1+offset or a fixed sample list.
  int cnt = 0;
  int seq_idx = 0;
  int seq_tab [4] = '{10, 11, 12, 14};
  int mch;
  always @(negedge clk) begin
    adc.adc_done = 1'b0;
    if (!seq_mode) seq_idx = 0;
    if (adc.adc_start) begin
      cnt = 5;
    end else if (cnt != 0) begin
      cnt--;
      if (cnt == 0) begin
        mch = int'({adc.mux_msb, adc.mux_lsb});
        if (!(hang_ch1 && mch == 1)) begin
          adc.adc_done = 1'b1;
          adc.adc_data = seq_mode ? RES_W'(seq_tab[seq_idx & 3]) : RES_W'(mch * 100 + 1 + offset);
          if (seq_mode) seq_idx++;
        end
      end
    end
  end

  int n_start = 0, n_valid = 0, n_round = 0, n_wide = 0;
  int cyc = 0, mux_chg_cyc = 0, first_gap = -1, last_start_cyc = 0, err_rise_cyc = 0;
  logic [1:0] mux_prev = 2'b00;
  logic [1:0] mux_now;
  logic start_prev = 1'b0, err_prev = 1'b0, gap_armed = 1'b0;
  logic [1:0] start_mux [$];
  always @(negedge clk) begin
    cyc++;
    mux_now = {adc.mux_msb, adc.mux_lsb};
    if (mux_now !== mux_prev) begin
      mux_chg_cyc = cyc;
      gap_armed   = 1'b1;
    end
    mux_prev = mux_now;
    if (adc.adc_start === 1'b1) begin
      n_start++;
      last_start_cyc = cyc;
      start_mux.push_back(mux_now);
      if (gap_armed) begin
        first_gap = cyc - mux_chg_cyc;
        gap_armed = 1'b0;
      end
      if (start_prev) n_wide++;
    end
    start_prev = (adc.adc_start === 1'b1);
    if (res_valid === 1'b1) n_valid++;
    if (round_done === 1'b1) n_round++;
    if (err_timeout === 1'b1 && !err_prev) err_rise_cyc = cyc;
    err_prev = (err_timeout === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input logic cont);
    cfg_chmask = mask;
    cfg_cont   = cont;
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  task automatic waitIdle(input int maxc, input string tag);
    int k = 0;
    while (busy && k < maxc) begin
      tick(1);
      k++;
    end
    checkOutput({tag, "_idle"}, busy, 0);
  endtask

  function automatic logic [RES_W-1:0] slot(input int n);
    return res_all[n*RES_W +: RES_W];
  endfunction

  int s0, v0, r0, q0, k;

  initial begin
    rst = 1'b1; cfg_en = 1'b0; cfg_chmask = 4'b0; cfg_cont = 1'b0; start = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_strobes", {adc.adc_start, res_valid, round_done, err_timeout}, 0);
    checkOutput("rst_mux", {adc.mux_msb, adc.mux_lsb, res_ch}, 0);
    checkOutput("rst_res_all", res_all, 0);

    $display("[TB] single round, mask 0101");
    cfg_en = 1'b1;
    s0 = n_start; v0 = n_valid; r0 = n_round; q0 = start_mux.size();
    applyStimulus(4'b0101, 1'b0);
    checkOutput("t1_busy", busy, 1);
    waitIdle(400, "t1");
    tick(1);
    checkOutput("t1_ch0", slot(0), 1);
    checkOutput("t1_ch2", slot(2), 201);
    checkOutput("t1_ch1_ch3", {slot(1), slot(3)}, 0);
    checkOutput("t1_valid", n_valid - v0, 2);
    checkOutput("t1_rounds", n_round - r0, 1);
    checkOutput("t1_starts", n_start - s0, 2 * NS);
    checkOutput("t1_mux_first", start_mux[q0], 0);
    checkOutput("t1_mux_second", start_mux[q0 + NS], 2);
    checkOutput("t1_settle_gap", first_gap, 16);
    checkOutput("t1_start_width", n_wide, 0);
    checkOutput("t1_res_ch", res_ch, 2);

    $display("[TB] start with empty mask");
    s0 = n_start;
    applyStimulus(4'b0000, 1'b0);
    tick(3);
    checkOutput("m0_busy", busy, 0);
    checkOutput("m0_starts", n_start - s0, 0);

    $display("[TB] continuous on ch3, abort in settle");
    r0 = n_round;
    applyStimulus(4'b1000, 1'b1);
    k = 0;
    while (!(n_round >= r0 + 1 && round_done) && k < 600) begin
      tick(1);
      k++;
    end
    checkOutput("cont_round_seen", round_done, 1);
    tick(3);
    checkOutput("cont_still_busy", busy, 1);
    s0 = n_start;
    cfg_en = 1'b0;
    tick(1);
    checkOutput("abort_busy", busy, 0);
    r0 = n_round + 0;
    v0 = n_round;
    tick(30);
    checkOutput("abort_no_start", n_start - s0, 0);
    checkOutput("abort_no_round", n_round - v0, 0);
    checkOutput("abort_mux_hold", {adc.mux_msb, adc.mux_lsb}, 3);
    checkOutput("cont_ch3", slot(3), 301);

    $display("[TB] timeout on ch1, mask 0011");
    cfg_en = 1'b1; hang_ch1 = 1'b1; offset = 7;
    v0 = n_valid; r0 = n_round;
    applyStimulus(4'b0011, 1'b0);
    waitIdle(3000, "tmo");
    tick(1);
    checkOutput("tmo_err", err_timeout, 1);
    checkOutput("tmo_ch0", slot(0), 8);
    checkOutput("tmo_ch1", slot(1), 0);
    checkOutput("tmo_valid", n_valid - v0, 1);
    checkOutput("tmo_rounds", n_round - r0, 1);
    checkOutput("tmo_latency", err_rise_cyc - last_start_cyc, 1024);

    $display("[TB] start clears error, start while busy ignored");
    hang_ch1 = 1'b0; offset = 20;
    v0 = n_valid; r0 = n_round;
    applyStimulus(4'b0001, 1'b0);
    checkOutput("clr_err", err_timeout, 0);
    tick(4);
    applyStimulus(4'b1111, 1'b0);
    waitIdle(400, "busy_start");
    tick(1);
    checkOutput("bs_ch0", slot(0), 21);
    checkOutput("bs_ch1", slot(1), 0);
    checkOutput("bs_valid", n_valid - v0, 1);
    checkOutput("bs_rounds", n_round - r0, 1);

    $display("[TB] sample sequence 10,11,12,14 on ch0");
    seq_mode = 1'b1;
    s0 = n_start; v0 = n_valid;
    applyStimulus(4'b0001, 1'b0);
    waitIdle(400, "seq");
    tick(1);
    checkOutput("seq_ch0", slot(0), SEQ_EXP);
    checkOutput("seq_starts", n_start - s0, NS);
    checkOutput("seq_valid", n_valid - v0, 1);
    seq_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
